// File: rtl/m_axis_rc_adapt_x4_pkg.sv
// Shared definitions for the x4 requester-completion adapter: RC descriptor field
// offsets, completion fmt/type and status codes, and tuser bit positions.
package m_axis_rc_adapt_x4_pkg;

  // RC descriptor field positions within beat 0 (bit offsets into tdata).
  localparam int unsigned RcLowerAddrLsb   = 0;
  localparam int unsigned RcErrorCodeLsb   = 12;
  localparam int unsigned RcByteCountLsb   = 16;
  localparam int unsigned RcLockedBit      = 29;
  localparam int unsigned RcDwordCountLsb  = 32;
  localparam int unsigned RcStatusLsb      = 43;
  localparam int unsigned RcPoisonedBit    = 46;
  localparam int unsigned RcRequesterIdLsb = 48;
  localparam int unsigned RcTagLsb         = 64;
  localparam int unsigned RcCompleterIdLsb = 72;
  localparam int unsigned RcTcLsb          = 89;
  localparam int unsigned RcAttrLsb        = 92;

  // tuser bit positions on the RC input and the TLP output.
  localparam int unsigned RcTuserDiscontinue = 42;
  localparam int unsigned TlpUserDiscontinue = 0;
  localparam int unsigned TlpUserError       = 1;

  // A data-less completion carries only the 3-DW header.
  localparam logic [15:0] HdrOnlyKeep = 16'h0FFF;

  typedef enum logic [7:0] {
    FmtTypeCpl    = 8'h0A,
    FmtTypeCplLk  = 8'h0B,
    FmtTypeCplD   = 8'h4A,
    FmtTypeCplDLk = 8'h4B
  } cpl_fmt_type_e;

  typedef enum logic [2:0] {
    CplStatusSc  = 3'b000,
    CplStatusUr  = 3'b001,
    CplStatusCrs = 3'b010,
    CplStatusCa  = 3'b100
  } cpl_status_e;

  // Expand a dword keep to a byte keep (each dword bit covers four bytes).
  function automatic logic [15:0] expand_dw_keep(input logic [3:0] dw_keep);
    logic [15:0] byte_keep;
    for (int i = 0; i < 4; i++) begin
      byte_keep[4*i +: 4] = {4{dw_keep[i]}};
    end
    return byte_keep;
  endfunction

endpackage

// File: rtl/m_axis_rc_adapt_x4_if.sv
// Generic AXI4-Stream bundle. master drives payload/valid, slave drives ready.
//   tdata/tkeep/tuser/tlast/tvalid : master -> slave
//   tready                         : slave -> master
interface m_axis_rc_adapt_x4_if #(
  parameter int unsigned DataWidth = 128,
  parameter int unsigned KeepWidth = 16,
  parameter int unsigned UserWidth = 4
);
  logic [DataWidth-1:0] tdata;
  logic [KeepWidth-1:0] tkeep;
  logic [UserWidth-1:0] tuser;
  logic                 tlast;
  logic                 tvalid;
  logic                 tready;

  modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_skid_n.sv
// One-entry registered skid buffer with a registered output stage.
//   in_*  : upstream AXIS handshake; in_ready_o is a flop ("skid empty").
//   out_* : downstream AXIS handshake; data/valid held while out_ready_i is low.
// A beat accepted while the output register drains goes straight to the output,
// so the skid only fills when the output is stalled.
module axis_skid_n #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [Width-1:0] out_data_q, out_data_d;
  logic [Width-1:0] skid_data_q, skid_data_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             in_fire;

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    in_fire      = in_valid_i & in_ready_q;

    if (!out_valid_q || out_ready_i) begin
      if (skid_valid_q) begin
        // in_ready_q is low whenever the skid holds data, so no input competes here.
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) begin
          out_data_d = in_data_i;
        end
      end
    end else if (in_fire) begin
      skid_data_d  = in_data_i;
      skid_valid_d = 1'b1;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/m_axis_rc_adapt_x4.sv
// UltraScale+ Requester Completion (RC) to LitePCIe 128-bit completion TLP adapter.
//   user_clk, user_reset_n : clock, asynchronous active-low reset
//   rc_a_if (slave)        : RC stream from the PCIe IP (128b data, 4b dword keep, 75b user)
//   rc_if (master)         : TLP stream (128b data, 16b byte keep, 4b user:
//                            [0] discontinue, [1] completion error)
// Beat 0 of each packet has its 3-DW RC descriptor rewritten in place into a 3-DW
// completion header; DW3 and all later beats pass through. Sequencing is carried by
// a one-entry skid placed after the combinational rewrite.
module m_axis_rc_adapt_x4
  import m_axis_rc_adapt_x4_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                 user_clk,
  input  logic                 user_reset_n,
  m_axis_rc_adapt_x4_if.slave  rc_a_if,
  m_axis_rc_adapt_x4_if.master rc_if
);

  localparam int unsigned PayloadWidth = 4 + 1 + KEEP_WIDTH + DATA_WIDTH;

  logic        first_q, first_d;
  logic        err_q, err_d;
  logic        in_ready;
  logic        in_fire;

  logic [95:0] desc;
  logic [11:0] lower_addr;
  logic [3:0]  error_code;
  logic [12:0] byte_count;
  logic        locked;
  logic [10:0] dword_count;
  logic [2:0]  status;
  logic        poisoned;
  logic [15:0] requester_id;
  logic [7:0]  tag;
  logic [15:0] completer_id;
  logic [2:0]  tc;
  logic [2:0]  attr;

  logic [7:0]            fmt_type;
  logic [31:0]           hdr_dw0, hdr_dw1, hdr_dw2;
  logic [DATA_WIDTH-1:0] tdata_x;
  logic [KEEP_WIDTH-1:0] tkeep_x;
  logic [3:0]            tuser_x;
  logic                  cpl_err;

  logic [PayloadWidth-1:0] skid_in, skid_out;

  always_comb begin
    desc         = rc_a_if.tdata[95:0];
    lower_addr   = desc[RcLowerAddrLsb +: 12];
    error_code   = desc[RcErrorCodeLsb +: 4];
    byte_count   = desc[RcByteCountLsb +: 13];
    locked       = desc[RcLockedBit];
    dword_count  = desc[RcDwordCountLsb +: 11];
    status       = desc[RcStatusLsb +: 3];
    poisoned     = desc[RcPoisonedBit];
    requester_id = desc[RcRequesterIdLsb +: 16];
    tag          = desc[RcTagLsb +: 8];
    completer_id = desc[RcCompleterIdLsb +: 16];
    tc           = desc[RcTcLsb +: 3];
    attr         = desc[RcAttrLsb +: 3];
  end

  always_comb begin
    if (dword_count == '0) begin
      fmt_type = locked ? FmtTypeCplLk : FmtTypeCpl;
    end else begin
      fmt_type = locked ? FmtTypeCplDLk : FmtTypeCplD;
    end
    // Length 1024 and byte count 4096 wrap to zero by truncation.
    hdr_dw0 = {fmt_type, 1'b0, tc, 4'b0, 1'b0, poisoned, attr[1:0], 2'b0, dword_count[9:0]};
    hdr_dw1 = {completer_id, status, 1'b0, byte_count[11:0]};
    hdr_dw2 = {requester_id, tag, 1'b0, lower_addr[6:0]};

    if (first_q) begin
      tdata_x = {rc_a_if.tdata[127:96], hdr_dw2, hdr_dw1, hdr_dw0};
    end else begin
      tdata_x = rc_a_if.tdata;
    end

    if (first_q && (dword_count == '0)) begin
      tkeep_x = HdrOnlyKeep;
    end else begin
      tkeep_x = expand_dw_keep(rc_a_if.tkeep);
    end

    // The error flag comes live from the header beat and from the latch afterwards.
    cpl_err = first_q ? (error_code != '0) : err_q;

    tuser_x                     = '0;
    tuser_x[TlpUserDiscontinue] = rc_a_if.tuser[RcTuserDiscontinue];
    tuser_x[TlpUserError]       = cpl_err;
  end

  assign in_fire = rc_a_if.tvalid & in_ready;

  always_comb begin
    first_d = first_q;
    err_d   = err_q;
    if (in_fire) begin
      first_d = rc_a_if.tlast;
      err_d   = cpl_err;
    end
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      first_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  assign skid_in = {tuser_x, rc_a_if.tlast, tkeep_x, tdata_x};

  axis_skid_n #(
    .Width (PayloadWidth)
  ) u_skid (
    .clk_i       (user_clk),
    .rst_ni      (user_reset_n),
    .in_data_i   (skid_in),
    .in_valid_i  (rc_a_if.tvalid),
    .in_ready_o  (in_ready),
    .out_data_o  (skid_out),
    .out_valid_o (rc_if.tvalid),
    .out_ready_i (rc_if.tready)
  );

  assign rc_a_if.tready = in_ready;
  assign {rc_if.tuser, rc_if.tlast, rc_if.tkeep, rc_if.tdata} = skid_out;

  // Descriptor and user bits the completion header does not carry.
  logic unused_bits;
  assign unused_bits = ^{desc[31:30], desc[47], desc[88], desc[95], byte_count[12],
                         lower_addr[11:7], attr[2], dword_count[10],
                         rc_a_if.tuser[74:43], rc_a_if.tuser[41:0]};

endmodule

// File: tb/tb_m_axis_rc_adapt_x4.sv
module tb_m_axis_rc_adapt_x4;

  logic user_clk = 1'b0;
  logic user_reset_n = 1'b0;
  always #5 user_clk = ~user_clk;

  m_axis_rc_adapt_x4_if #(.DataWidth(128), .KeepWidth(4), .UserWidth(75)) rc_a_if ();
  m_axis_rc_adapt_x4_if #(.DataWidth(128), .KeepWidth(16), .UserWidth(4)) rc_if ();

  m_axis_rc_adapt_x4 #(.DATA_WIDTH(128)) dut (
    .user_clk     (user_clk),
    .user_reset_n (user_reset_n),
    .rc_a_if      (rc_a_if),
    .rc_if        (rc_if)
  );

  typedef struct packed {
    logic [11:0] la;
    logic [3:0]  ec;
    logic [12:0] bc;
    logic        lk;
    logic [10:0] dc;
    logic [2:0]  st;
    logic        ep;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [15:0] cid;
    logic [2:0]  tc;
    logic [2:0]  attr;
  } hdr_t;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
    logic [74:0]  user;
  } in_beat_t;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic [3:0]   user;
  } exp_beat_t;

  in_beat_t  in_q[$];
  exp_beat_t exp_q[$];
  int        in_cycles[$];

  int n_checks = 0;
  int n_pass = 0;

  logic [127:0] first_out_data;
  logic [15:0]  first_out_keep;
  logic [15:0]  last_out_keep;
  logic [3:0]   first_out_user;
  hdr_t         h;
  int           cycles;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [74:0] rand_user(input logic disc);
    logic [74:0] u;
    u[31:0]  = $urandom;
    u[63:32] = $urandom;
    u[74:64] = 11'($urandom);
    u[42]    = disc;
    return u;
  endfunction

  function automatic hdr_t rand_hdr();
    hdr_t r;
    r = hdr_t'({$urandom, $urandom, $urandom});
    case ($urandom_range(0, 3))
      0:       r.dc = 11'd0;
      1:       r.dc = 11'd1024;
      default: r.dc = 11'($urandom_range(1, 1023));
    endcase
    if ($urandom_range(0, 1) == 0) r.ec = 4'd0;
    return r;
  endfunction

  // Reference model: one completion in, expected TLP beats out.
  task automatic push_pkt(input hdr_t hd, input int nbeats, input logic [31:0] dw3,
                          input logic [3:0] last_keep, input bit rand_disc);
    logic [7:0]  fmt;
    logic [31:0] e0, e1, e2;
    bit          err;
    err = (hd.ec != 4'd0);
    fmt = 8'h0A + (hd.lk ? 8'h01 : 8'h00) + ((hd.dc != 11'd0) ? 8'h40 : 8'h00);
    e0 = ({24'h0, fmt} << 24) | (32'(hd.tc) << 20) | (32'(hd.ep) << 14)
       | (32'(hd.attr & 3'b011) << 12) | (32'(hd.dc) % 1024);
    e1 = (32'(hd.cid) << 16) | (32'(hd.st) << 13) | (32'(hd.bc) % 4096);
    e2 = (32'(hd.rid) << 16) | (32'(hd.tag) << 8) | (32'(hd.la) % 128);
    for (int b = 0; b < nbeats; b++) begin
      in_beat_t  ib;
      exp_beat_t eb;
      logic      disc;
      disc = rand_disc ? ($urandom_range(0, 7) == 0) : 1'b0;
      ib.data = rand128();
      if (b == 0) begin
        ib.data[11:0]   = hd.la;
        ib.data[15:12]  = hd.ec;
        ib.data[28:16]  = hd.bc;
        ib.data[29]     = hd.lk;
        ib.data[42:32]  = hd.dc;
        ib.data[45:43]  = hd.st;
        ib.data[46]     = hd.ep;
        ib.data[63:48]  = hd.rid;
        ib.data[71:64]  = hd.tag;
        ib.data[87:72]  = hd.cid;
        ib.data[91:89]  = hd.tc;
        ib.data[94:92]  = hd.attr;
        ib.data[127:96] = dw3;
      end
      ib.keep = (b == nbeats - 1) ? last_keep : 4'hF;
      ib.last = (b == nbeats - 1);
      ib.user = rand_user(disc);
      in_q.push_back(ib);

      eb.data = (b == 0) ? {dw3, e2, e1, e0} : ib.data;
      eb.keep = 16'h0;
      for (int i = 0; i < 4; i++) if (ib.keep[i]) eb.keep = eb.keep | (16'hF << (4 * i));
      if (b == 0 && hd.dc == 11'd0) eb.keep = 16'h0FFF;
      eb.last = ib.last;
      eb.user = {2'b00, err, disc};
      exp_q.push_back(eb);
    end
  endtask

  // rdy_mode: 0 always ready, 1 toggle, 2 random. vld_mode: 0 always, 1 random gaps.
  task automatic run(input int rdy_mode, input int vld_mode, input int abort_after,
                     input bit chk_lat, output int cyc);
    int           accepted;
    int           nout;
    bit           presenting;
    bit           stall;
    bit           done;
    bit           in_fire;
    bit           out_fire;
    logic [127:0] stall_data;
    exp_beat_t    eb;
    cyc = 0; accepted = 0; nout = 0; presenting = 0; stall = 0; done = 0;
    stall_data = '0;
    in_cycles.delete();
    while (!done) begin
      if (!presenting && in_q.size() > 0 && (vld_mode == 0 || $urandom_range(0, 3) != 0)) begin
        rc_a_if.tdata = in_q[0].data;
        rc_a_if.tkeep = in_q[0].keep;
        rc_a_if.tlast = in_q[0].last;
        rc_a_if.tuser = in_q[0].user;
        presenting = 1;
      end
      rc_a_if.tvalid = presenting;
      case (rdy_mode)
        0:       rc_if.tready = 1'b1;
        1:       rc_if.tready = (cyc % 2 == 0);
        default: rc_if.tready = 1'($urandom_range(0, 1));
      endcase
      #4;
      if (stall) begin
        check("hold_valid", 128'(rc_if.tvalid), 128'(1));
        check("hold_data", rc_if.tdata, stall_data);
      end
      in_fire  = rc_a_if.tvalid && rc_a_if.tready;
      out_fire = rc_if.tvalid && rc_if.tready;
      if (out_fire) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 128'(1), 128'(0));
        end else begin
          eb = exp_q.pop_front();
          check("tdata", rc_if.tdata, eb.data);
          check("tkeep", 128'(rc_if.tkeep), 128'(eb.keep));
          check("tlast", 128'(rc_if.tlast), 128'(eb.last));
          check("tuser", 128'(rc_if.tuser), 128'(eb.user));
          if (nout == 0) begin
            first_out_data = rc_if.tdata;
            first_out_keep = rc_if.tkeep;
            first_out_user = rc_if.tuser;
          end
          last_out_keep = rc_if.tkeep;
          if (chk_lat && in_cycles.size() > 0) check("latency", 128'(cyc - in_cycles.pop_front()), 128'(1));
        end
        nout++;
      end
      stall      = rc_if.tvalid && !rc_if.tready;
      stall_data = rc_if.tdata;
      if (in_fire) begin
        void'(in_q.pop_front());
        presenting = 0;
        accepted++;
        in_cycles.push_back(cyc);
      end
      @(posedge user_clk);
      #1;
      cyc++;
      if (abort_after != 0 && accepted == abort_after) done = 1;
      if (in_q.size() == 0 && exp_q.size() == 0) done = 1;
      if (cyc >= 3000) done = 1;
    end
    rc_a_if.tvalid = 1'b0;
    rc_if.tready   = 1'b1;
    if (abort_after == 0) check("drained", 128'(in_q.size() + exp_q.size()), 128'(0));
  endtask

  initial begin
    rc_a_if.tdata  = '0;
    rc_a_if.tkeep  = '0;
    rc_a_if.tlast  = 1'b0;
    rc_a_if.tuser  = '0;
    rc_a_if.tvalid = 1'b0;
    rc_if.tready   = 1'b1;

    // Reset state.
    repeat (3) @(posedge user_clk);
    #1;
    check("rst_tvalid", 128'(rc_if.tvalid), 128'(0));
    check("rst_tready_a", 128'(rc_a_if.tready), 128'(0));
    check("rst_tdata", rc_if.tdata, 128'(0));
    check("rst_tkeep_tuser_tlast", 128'({rc_if.tkeep, rc_if.tuser, rc_if.tlast}), 128'(0));
    @(negedge user_clk);
    user_reset_n = 1'b1;
    #1;
    check("tready_a_before_edge", 128'(rc_a_if.tready), 128'(0));
    @(posedge user_clk);
    #1;
    check("tready_a_after_edge", 128'(rc_a_if.tready), 128'(1));

    // 1-DW CplD.
    h = '0; h.dc = 11'd1; h.bc = 13'd4; h.tag = 8'h12; h.la = 12'h004;
    h.rid = 16'hABCD; h.cid = 16'h1234;
    push_pkt(h, 1, 32'hDEADBEEF, 4'hF, 0);
    run(0, 0, 0, 1, cycles);
    check("cpld1_dw0", 128'(first_out_data[31:0]), 128'(32'h4A000001));
    check("cpld1_dw1", 128'(first_out_data[63:32]), 128'(32'h12340004));
    check("cpld1_dw2", 128'(first_out_data[95:64]), 128'(32'hABCD1204));
    check("cpld1_dw3", 128'(first_out_data[127:96]), 128'(32'hDEADBEEF));
    check("cpld1_keep", 128'(first_out_keep), 128'(16'hFFFF));

    // 32-DW CplD, 9 beats, downstream ready toggling.
    h = '0; h.dc = 11'd32; h.bc = 13'd128; h.tag = 8'h33; h.rid = 16'h0100; h.cid = 16'h0200;
    push_pkt(h, 9, 32'h01020304, 4'b0001, 0);
    run(1, 0, 0, 0, cycles);
    check("cpld32_dw0", 128'(first_out_data[31:0]), 128'(32'h4A000020));
    check("cpld32_last_keep", 128'(last_out_keep), 128'(16'h000F));

    // UR completion without data.
    h = '0; h.dc = 11'd0; h.st = 3'b001; h.ec = 4'h2; h.rid = 16'h5555; h.cid = 16'h6666;
    push_pkt(h, 1, 32'h0, 4'hF, 0);
    run(0, 0, 0, 1, cycles);
    check("ur_dw0", 128'(first_out_data[31:0]), 128'(32'h0A000000));
    check("ur_status", 128'(first_out_data[47:45]), 128'(3'b001));
    check("ur_keep", 128'(first_out_keep), 128'(16'h0FFF));
    check("ur_err", 128'(first_out_user[1]), 128'(1));

    // Locked CplD, 1024 DW / 4096 bytes.
    h = '0; h.lk = 1'b1; h.dc = 11'd1024; h.bc = 13'd4096; h.rid = 16'h7777; h.cid = 16'h8888;
    push_pkt(h, 2, 32'hCAFEF00D, 4'hF, 0);
    run(2, 0, 0, 0, cycles);
    check("lk_dw0", 128'(first_out_data[31:0]), 128'(32'h4B000000));
    check("lk_bc", 128'(first_out_data[43:32]), 128'(0));

    // Back-to-back 2-beat + 1-beat at full throughput.
    push_pkt(rand_hdr(), 2, $urandom, 4'hF, 1);
    push_pkt(rand_hdr(), 1, $urandom, 4'h3, 1);
    run(0, 0, 0, 1, cycles);
    check("b2b_cycles", 128'(cycles), 128'(4));

    // Randomized traffic.
    for (int p = 0; p < 40; p++)
      push_pkt(rand_hdr(), $urandom_range(1, 5), $urandom, 4'($urandom_range(1, 15)), 1);
    run(2, 1, 0, 0, cycles);
    for (int p = 0; p < 20; p++)
      push_pkt(rand_hdr(), $urandom_range(1, 4), $urandom, 4'($urandom_range(1, 15)), 1);
    run(1, 0, 0, 0, cycles);

    // Reset in the middle of a 9-beat packet.
    push_pkt(rand_hdr(), 9, $urandom, 4'hF, 0);
    run(2, 0, 3, 0, cycles);
    user_reset_n = 1'b0;
    #2;
    check("midrst_tvalid", 128'(rc_if.tvalid), 128'(0));
    check("midrst_tready_a", 128'(rc_a_if.tready), 128'(0));
    in_q.delete();
    exp_q.delete();
    repeat (2) @(posedge user_clk);
    @(negedge user_clk);
    user_reset_n = 1'b1;
    @(posedge user_clk);
    #1;
    h = '0; h.dc = 11'd1; h.bc = 13'd4; h.tag = 8'h12; h.la = 12'h004;
    h.rid = 16'hABCD; h.cid = 16'h1234;
    push_pkt(h, 1, 32'hDEADBEEF, 4'hF, 0);
    run(0, 0, 0, 1, cycles);
    check("postrst_dw0", 128'(first_out_data[31:0]), 128'(32'h4A000001));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
